md5_msg_sched: RTL

- Upstream feeder for the MD5 round controller.
- Accepts the 16 32-bit words of each 512-bit message block over a valid/ready stream into a two-bank ping-pong buffer.
- Starts a block by pulsing DataVld to the controller, then drives the message word M[g] that each of the 64 rounds needs.
- Tracks rounds with its own counter and cross-checks it against the controller's RoundNum.

---
 rtl/md5_msg_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/md5_msg_sched.sv
// MD5 message scheduler: buffers 512-bit message blocks (16 x 32-bit words)
// in a two-bank ping-pong store and feeds the round controller the word M[g]
// needed by each of the 64 rounds.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   InVld / InData     upstream word stream (stored as presented)
//   InRdy              buffer can accept a word this cycle
//   RoundNum           round index reported by the round controller
//   DataVld            one-cycle block-start pulse to the round controller
//   DataIn             message word for the current round (0 while idle)
//   Busy               a block is being issued
//   SchedErr           sticky: RoundNum disagreed with the internal round count
module md5_msg_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  InVld,
  input  logic [DATA_WIDTH-1:0] InData,
  output logic                  InRdy,
  input  logic [5:0]            RoundNum,
  output logic                  DataVld,
  output logic [DATA_WIDTH-1:0] DataIn,
  output logic                  Busy,
  output logic                  SchedErr
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned RND_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RUN
  } state_e;

  state_e              state_q, state_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]    wr_idx_q, wr_idx_d;
  logic [1:0]          full_q, full_d;
  logic [RND_W-1:0]    rnd_q, rnd_d;
  logic                err_q, err_d;
  logic                hs;
  logic [1:0]          full_set;
  logic [1:0]          full_clr;
  logic [IDX_W-1:0]    g_idx;

  logic [DATA_WIDTH-1:0] mem_q [2][NUM_WORDS];

  // Write side: a bank accepts words until its 16th word lands
  assign InRdy = !full_q[wr_bank_q];
  assign hs    = InVld & InRdy;

  // Message storage; contents are only meaningful once the bank is flagged full
  always_ff @(posedge clk) begin
    if (hs) begin
      mem_q[wr_bank_q][wr_idx_q] <= InData;
    end
  end

  // MD5 message index g(rnd); all arithmetic wraps mod 16
  always_comb begin
    g_idx = rnd_q[3:0];
    case (rnd_q[5:4])
      2'd0:    g_idx = rnd_q[3:0];
      2'd1:    g_idx = rnd_q[3:0] * 4'd5 + 4'd1;
      2'd2:    g_idx = rnd_q[3:0] * 4'd3 + 4'd5;
      default: g_idx = rnd_q[3:0] * 4'd7;
    endcase
  end

  // Write pointer and fill flags; set and release may hit different banks in one cycle
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    full_set  = 2'b00;
    if (hs) begin
      wr_idx_d = wr_idx_q + IDX_W'(1);
      if (wr_idx_q == IDX_W'(NUM_WORDS - 1)) begin
        full_set[wr_bank_q] = 1'b1;
        wr_bank_d           = ~wr_bank_q;
      end
    end
    full_d = (full_q & ~full_clr) | full_set;
  end

  // Read FSM: next state, round counter, bank release and outputs
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    rd_bank_d = rd_bank_q;
    full_clr  = 2'b00;
    err_d     = err_q;
    DataVld   = 1'b0;
    Busy      = 1'b0;
    DataIn    = '0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = START;
        end
      end
      START: begin
        DataVld = 1'b1;
        Busy    = 1'b1;
        DataIn  = mem_q[rd_bank_q][g_idx];
        rnd_d   = RND_W'(1);
        state_d = RUN;
      end
      RUN: begin
        Busy   = 1'b1;
        DataIn = mem_q[rd_bank_q][g_idx];
        rnd_d  = rnd_q + RND_W'(1);
        if (rnd_q == RND_W'(63)) begin
          full_clr[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          rnd_d               = '0;
          state_d             = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Controller must track our round count exactly while a block is issued
    if ((state_q != IDLE) && (RoundNum != rnd_q)) begin
      err_d = 1'b1;
    end
  end

  assign SchedErr = err_q;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      full_q    <= 2'b00;
      rnd_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      rnd_q     <= rnd_d;
      err_q     <= err_d;
    end
  end

endmodule
